// File: rtl/test_sequencer.sv
// test_sequencer
//   Steps a tuning campaign over NUM_CANDIDATES overlay configurations. For
//   each candidate it requests the configuration, starts the frequency
//   tester, waits for a result (or a timeout), and tracks the best score and
//   the index that produced it.
//
// Ports
//   clock          sole clock, rising edge
//   reset          synchronous, active-high
//   run            start a campaign (only honoured while idle)
//   abort          cancel the campaign in progress
//   cfg_req        request load of configuration cfg_index
//   cfg_index      candidate being configured/tested
//   cfg_ack        configuration loaded
//   tester_start   one-cycle start pulse to the frequency tester
//   tester_done    tester complete
//   tester_score   tester score, valid while tester_done is high
//   best_score     highest score this campaign
//   best_index     candidate that produced best_score
//   busy           campaign in progress
//   finished       campaign completed normally
//   timeout_err    sticky, one or more tests timed out
module test_sequencer #(
   parameter int unsigned NUM_CANDIDATES = 16,
   parameter int unsigned IDX_WIDTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4000000,
   parameter int unsigned TMO_WIDTH      = 23
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 abort,
   output logic                 cfg_req,
   output logic [IDX_WIDTH-1:0] cfg_index,
   input  logic                 cfg_ack,
   output logic                 tester_start,
   input  logic                 tester_done,
   input  logic [31:0]          tester_score,
   output logic [31:0]          best_score,
   output logic [IDX_WIDTH-1:0] best_index,
   output logic                 busy,
   output logic                 finished,
   output logic                 timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONFIG,
      S_START,
      S_WAIT,
      S_RECORD,
      S_NEXT
   } state_e;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CANDIDATES - 1);
   localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

   state_e                 state_q, state_d;
   logic                   cfg_req_q, cfg_req_d;
   logic                   tester_start_q, tester_start_d;
   logic                   busy_q, busy_d;
   logic                   finished_q, finished_d;
   logic                   timeout_err_q, timeout_err_d;
   logic [IDX_WIDTH-1:0]   cfg_index_q, cfg_index_d;
   logic [IDX_WIDTH-1:0]   best_index_q, best_index_d;
   logic [31:0]            best_score_q, best_score_d;
   logic [31:0]            score_q, score_d;
   logic [TMO_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;

   logic aborting;
   logic done_ok;
   logic tmo_hit;

   assign aborting = abort && (state_q != S_IDLE);
   // The tester clears its completion flag during the first WAIT cycle
   // (counter still 0), so a done seen then is stale.
   assign done_ok  = (state_q == S_WAIT) && tester_done && (tmo_cnt_q != '0);
   assign tmo_hit  = (state_q == S_WAIT) && (tmo_cnt_q == TMO_LAST);

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort outranks every other exit condition.
   always_comb begin
      state_d = state_q;
      if (aborting) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (run) state_d = S_CONFIG;
            S_CONFIG: if (cfg_ack) state_d = S_START;
            S_START:  state_d = S_WAIT;
            S_WAIT:   if (done_ok || tmo_hit) state_d = S_RECORD;
            S_RECORD: state_d = S_NEXT;
            S_NEXT:   state_d = (cfg_index_q == LAST_IDX) ? S_IDLE : S_CONFIG;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Output / datapath next values. Handshake outputs are decoded from the
   // next state so the registered copies line up with the state register.
   always_comb begin
      cfg_req_d      = (state_d == S_CONFIG);
      tester_start_d = (state_d == S_START);
      busy_d         = (state_d != S_IDLE);
      cfg_index_d    = cfg_index_q;
      best_index_d   = best_index_q;
      best_score_d   = best_score_q;
      finished_d     = finished_q;
      timeout_err_d  = timeout_err_q;
      score_d        = score_q;
      tmo_cnt_d      = '0;
      if (!aborting) begin
         case (state_q)
            S_IDLE: begin
               if (run) begin
                  cfg_index_d   = '0;
                  best_index_d  = '0;
                  best_score_d  = '0;
                  finished_d    = 1'b0;
                  timeout_err_d = 1'b0;
               end
            end
            S_WAIT: begin
               if (state_d == S_WAIT) tmo_cnt_d = tmo_cnt_q + TMO_WIDTH'(1);
               // A done coinciding with the last timeout cycle wins.
               if (done_ok) begin
                  score_d = tester_score;
               end else if (tmo_hit) begin
                  score_d       = '0;
                  timeout_err_d = 1'b1;
               end
            end
            S_RECORD: begin
               // Strict compare keeps the earliest index on ties.
               if (score_q > best_score_q) begin
                  best_score_d = score_q;
                  best_index_d = cfg_index_q;
               end
            end
            S_NEXT: begin
               if (cfg_index_q == LAST_IDX) begin
                  finished_d = 1'b1;
               end else begin
                  cfg_index_d = cfg_index_q + IDX_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cfg_req_q      <= 1'b0;
         tester_start_q <= 1'b0;
         busy_q         <= 1'b0;
         finished_q     <= 1'b0;
         timeout_err_q  <= 1'b0;
         cfg_index_q    <= '0;
         best_index_q   <= '0;
         best_score_q   <= '0;
         score_q        <= '0;
         tmo_cnt_q      <= '0;
      end else begin
         cfg_req_q      <= cfg_req_d;
         tester_start_q <= tester_start_d;
         busy_q         <= busy_d;
         finished_q     <= finished_d;
         timeout_err_q  <= timeout_err_d;
         cfg_index_q    <= cfg_index_d;
         best_index_q   <= best_index_d;
         best_score_q   <= best_score_d;
         score_q        <= score_d;
         tmo_cnt_q      <= tmo_cnt_d;
      end
   end

   assign cfg_req      = cfg_req_q;
   assign cfg_index    = cfg_index_q;
   assign tester_start = tester_start_q;
   assign best_score   = best_score_q;
   assign best_index   = best_index_q;
   assign busy         = busy_q;
   assign finished     = finished_q;
   assign timeout_err  = timeout_err_q;

endmodule
